alu4_cmd_seq: RTL

- Command sequencer for the team's 4-bit add/sub/inc/dec combinational datapath.
- Accepts opcode + operand commands over a valid/ready handshake and holds a W-bit accumulator.
- Drives the datapath control lines one step per cycle and captures its result. Multiply is done as a multi-cycle repeated-add loop.
- Returns result, carry and zero over a second valid/ready handshake.

---
 rtl/alu4_cmd_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu4_cmd_seq.sv
// Command sequencer for the 4-bit add/sub/inc/dec datapath: accepts commands over
// valid/ready, steps the datapath (multiply as repeated adds), returns result/carry/zero.
module alu4_cmd_seq #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [W-1:0] cmd_data,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_add,
   output logic         alu_sub,
   output logic         alu_inc,
   output logic         alu_switch,
   input  logic [W-1:0] alu_c,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_carry,
   output logic         rsp_zero,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, RESP = 2'd3} state_t;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_INC  = 3'd3;
   localparam logic [2:0] OP_DEC  = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   data_q, data_d, acc_q, acc_d, prod_q, prod_d, cnt_q, cnt_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic           alu_add_q, alu_add_d, alu_sub_q, alu_sub_d, alu_inc_q, alu_inc_d;
   logic           rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           cmd_ready_q, cmd_ready_d, busy_q, busy_d;

   // Datapath controls are registered, so they are set up one cycle ahead of the step that uses alu_c.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      acc_d       = acc_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      alu_a_d     = {W{1'b0}};
      alu_b_d     = {W{1'b0}};
      alu_add_d   = 1'b0;
      alu_sub_d   = 1'b0;
      alu_inc_d   = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_zero_d  = rsp_zero_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               if (cmd_op == OP_MUL) begin
                  state_d   = MUL;
                  prod_d    = {W{1'b0}};
                  cnt_d     = cmd_data;
                  carry_d   = 1'b0;
                  alu_a_d   = acc_q;
                  alu_add_d = (cmd_data != {W{1'b0}});
               end else begin
                  state_d = EXEC;
                  case (cmd_op)
                     OP_ADD:  begin alu_a_d = cmd_data; alu_b_d = acc_q; alu_add_d = 1'b1; end
                     OP_SUB:  begin alu_a_d = cmd_data; alu_b_d = acc_q; alu_sub_d = 1'b1; end
                     OP_INC:  begin alu_b_d = acc_q; alu_inc_d = 1'b1; end
                     OP_DEC:  alu_b_d = acc_q;
                     default: alu_b_d = {W{1'b0}};
                  endcase
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            state_d = RESP;
            case (op_q)
               OP_LOAD: begin acc_d = data_q; carry_d = 1'b0; end
               OP_ADD:  begin acc_d = alu_c; carry_d = (alu_c < acc_q); end
               OP_SUB:  begin acc_d = alu_c; carry_d = (data_q > acc_q); end
               OP_INC:  begin acc_d = alu_c; carry_d = (acc_q == {W{1'b1}}); end
               OP_DEC:  begin acc_d = alu_c; carry_d = (acc_q == {W{1'b0}}); end
               OP_CLR:  begin acc_d = {W{1'b0}}; carry_d = 1'b0; end
               default: carry_d = 1'b0;
            endcase
            rsp_valid_d = 1'b1;
            rsp_data_d  = acc_d;
            rsp_carry_d = carry_d;
            rsp_zero_d  = (acc_d == {W{1'b0}});
         end
         MUL: begin
            if (cnt_q != {W{1'b0}}) begin
               prod_d  = alu_c;
               carry_d = carry_q | (alu_c < prod_q);
               cnt_d   = cnt_q - W'(1);
               if (cnt_q != W'(1)) begin
                  alu_a_d   = acc_q;
                  alu_b_d   = alu_c;
                  alu_add_d = 1'b1;
               end else begin
                  alu_add_d = 1'b0;
               end
            end else begin
               acc_d       = prod_q;
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = prod_q;
               rsp_carry_d = carry_q;
               rsp_zero_d  = (prod_q == {W{1'b0}});
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State, accumulator and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 3'd0;
         data_q      <= {W{1'b0}};
         acc_q       <= {W{1'b0}};
         prod_q      <= {W{1'b0}};
         cnt_q       <= {W{1'b0}};
         carry_q     <= 1'b0;
         alu_a_q     <= {W{1'b0}};
         alu_b_q     <= {W{1'b0}};
         alu_add_q   <= 1'b0;
         alu_sub_q   <= 1'b0;
         alu_inc_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {W{1'b0}};
         rsp_carry_q <= 1'b0;
         rsp_zero_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_add_q   <= alu_add_d;
         alu_sub_q   <= alu_sub_d;
         alu_inc_q   <= alu_inc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_zero_q  <= rsp_zero_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_add    = alu_add_q;
   assign alu_sub    = alu_sub_q;
   assign alu_inc    = alu_inc_q;
   assign alu_switch = 1'b0;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;
   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;

endmodule
